// File: rtl/dip_switch_bank_pkg.sv
// Shared definitions for the host-programmable DIP switch bank:
// bridge offsets, control/status bit positions and the restore FSM state type.
package dip_switch_bank_pkg;

  // Offsets within the 512-byte window decoded from BASE_ADDR.
  localparam logic [8:0] STAGE_OFS  = 9'h000;
  localparam logic [8:0] ACTIVE_OFS = 9'h080;
  localparam logic [8:0] CTRL_OFS   = 9'h100;
  localparam logic [8:0] STATUS_OFS = 9'h104;

  localparam int unsigned CTRL_APPLY_BIT   = 0;
  localparam int unsigned CTRL_RESTORE_BIT = 1;

  localparam int unsigned STAT_DIRTY_BIT   = 0;
  localparam int unsigned STAT_BUSY_BIT    = 1;
  localparam int unsigned STAT_PENDING_BIT = 2;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_RESTORE = 1'b1
  } state_e;

  // Index width that stays legal for a single-bank configuration.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dip_switch_bank_if.sv
// APF bridge slice seen by the DIP switch bank: address, single-cycle
// write/read strobes, write data and registered read data.
interface dip_switch_bank_if;

  logic [31:0] bridge_addr;
  logic        bridge_wr;
  logic [31:0] bridge_wr_data;
  logic        bridge_rd;
  logic [31:0] bridge_rd_data;

  modport master (
    output bridge_addr,
    output bridge_wr,
    output bridge_wr_data,
    output bridge_rd,
    input  bridge_rd_data
  );

  modport slave (
    input  bridge_addr,
    input  bridge_wr,
    input  bridge_wr_data,
    input  bridge_rd,
    output bridge_rd_data
  );

endinterface

// File: rtl/dip_switch_bank.sv
// Staged/active DIP word register file: the host edits staging words, which are
// committed to the game only at a safe point; includes a sequenced restore.
module dip_switch_bank
  import dip_switch_bank_pkg::*;
#(
  parameter int unsigned                 NUM_BANKS = 2,
  parameter int unsigned                 WORD_W    = 16,
  parameter logic [31:0]                 BASE_ADDR = 32'hF100_0000,
  parameter logic [NUM_BANKS*WORD_W-1:0] DEFAULTS  = '0
) (
  input  logic                          clk,
  input  logic                          reset,
  dip_switch_bank_if.slave              bridge,
  input  logic                          apply_ok,
  output logic [NUM_BANKS*WORD_W-1:0]   dip_active,
  output logic                          dirty,
  output logic                          busy
);

  localparam int unsigned IDX_W = idx_width(NUM_BANKS);

  typedef logic [NUM_BANKS-1:0][WORD_W-1:0] bank_arr_t;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               dirty_q, dirty_d;
  logic               pending_q, pending_d;
  logic [31:0]        rd_data_q, rd_data_d;
  bank_arr_t          stage_q, stage_d;
  bank_arr_t          active_q, active_d;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic [8:0]     ofs;
  logic [4:0]     ofs_idx;
  logic           win_hit;
  logic           aligned;
  logic           stage_region;
  logic           active_region;
  logic           ctrl_hit;
  logic           status_hit;
  logic [NUM_BANKS-1:0] stage_hit;
  logic [NUM_BANKS-1:0] active_hit;

  assign ofs           = bridge.bridge_addr[8:0];
  assign ofs_idx       = ofs[6:2];
  assign win_hit       = (bridge.bridge_addr[31:9] == BASE_ADDR[31:9]);
  assign aligned       = (ofs[1:0] == 2'b00);
  assign stage_region  = win_hit && aligned && (ofs[8:7] == STAGE_OFS[8:7]);
  assign active_region = win_hit && aligned && (ofs[8:7] == ACTIVE_OFS[8:7]);
  assign ctrl_hit      = win_hit && (ofs == CTRL_OFS);
  assign status_hit    = win_hit && (ofs == STATUS_OFS);

  // ---------------------------------------------------------------------------
  // Command qualification
  // ---------------------------------------------------------------------------
  logic idle;
  logic stage_wr;
  logic stage_wr_any;
  logic ctrl_wr;
  logic apply_cmd;
  logic restore_start;
  logic restore_last;
  logic commit;

  assign idle          = (state_q == ST_IDLE);
  assign stage_wr      = bridge.bridge_wr && stage_region && idle;
  assign stage_wr_any  = stage_wr && (|stage_hit);
  assign ctrl_wr       = bridge.bridge_wr && ctrl_hit;
  assign apply_cmd     = ctrl_wr && bridge.bridge_wr_data[CTRL_APPLY_BIT];
  assign restore_start = ctrl_wr && bridge.bridge_wr_data[CTRL_RESTORE_BIT] && idle;
  assign restore_last  = (state_q == ST_RESTORE) && (idx_q == IDX_W'(NUM_BANKS - 1));

  // A restore issued together with apply runs first; the apply waits for IDLE.
  assign commit = (pending_q || apply_cmd) && apply_ok && idle && !restore_start;

  // ---------------------------------------------------------------------------
  // Per-bank staging/active next state
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
      logic restore_here;

      assign stage_hit[gi]  = stage_region  && (ofs_idx == 5'(gi));
      assign active_hit[gi] = active_region && (ofs_idx == 5'(gi));
      assign restore_here   = (state_q == ST_RESTORE) && (idx_q == IDX_W'(gi));

      always_comb begin
        stage_d[gi] = stage_q[gi];
        if (restore_here) begin
          stage_d[gi] = DEFAULTS[gi*WORD_W +: WORD_W];
        end else if (stage_wr && stage_hit[gi]) begin
          stage_d[gi] = bridge.bridge_wr_data[WORD_W-1:0];
        end
      end

      // Commit samples the pre-write staging value.
      assign active_d[gi] = commit ? stage_q[gi] : active_q[gi];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Restore FSM and flags
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    dirty_d   = dirty_q;
    pending_d = pending_q;

    case (state_q)
      ST_IDLE: begin
        if (restore_start) begin
          state_d = ST_RESTORE;
          idx_d   = '0;
        end
      end
      ST_RESTORE: begin
        idx_d = idx_q + IDX_W'(1);
        if (restore_last) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase

    if (commit) begin
      pending_d = 1'b0;
    end else if (apply_cmd) begin
      pending_d = 1'b1;
    end

    if (commit) begin
      dirty_d = 1'b0;
    end
    if (stage_wr_any || restore_last) begin
      dirty_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Read mux: one-cycle latency, value held until the next read strobe
  // ---------------------------------------------------------------------------
  logic [31:0] rd_word;

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (stage_hit[i]) begin
        rd_word = rd_word | 32'(stage_q[i]);
      end
      if (active_hit[i]) begin
        rd_word = rd_word | 32'(active_q[i]);
      end
    end
    if (status_hit) begin
      rd_word[STAT_DIRTY_BIT]   = dirty_q;
      rd_word[STAT_BUSY_BIT]    = (state_q == ST_RESTORE);
      rd_word[STAT_PENDING_BIT] = pending_q;
    end
    rd_data_d = bridge.bridge_rd ? rd_word : rd_data_q;
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      dirty_q   <= 1'b0;
      pending_q <= 1'b0;
      rd_data_q <= '0;
      stage_q   <= DEFAULTS;
      active_q  <= DEFAULTS;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      dirty_q   <= dirty_d;
      pending_q <= pending_d;
      rd_data_q <= rd_data_d;
      stage_q   <= stage_d;
      active_q  <= active_d;
    end
  end

  // Only low WORD_W and control bits of write data carry meaning.
  logic unused_wr_data;
  assign unused_wr_data = ^bridge.bridge_wr_data;

  assign bridge.bridge_rd_data = rd_data_q;
  assign dip_active            = active_q;
  assign dirty                 = dirty_q;
  assign busy                  = (state_q == ST_RESTORE);

endmodule

// File: tb/tb_dip_switch_bank.sv
// Directed bench for dip_switch_bank: two 16-bit banks, defaults {9CF7, 00FF}.
module tb_dip_switch_bank;

  localparam logic [31:0] BASE = 32'hF100_0000;
  localparam logic [31:0] DEFS = 32'h9CF7_00FF;

  logic        clk;
  logic        reset;
  logic        apply_ok;
  logic [31:0] dip_active;
  logic        dirty;
  logic        busy;

  int errors = 0;
  int checks = 0;

  dip_switch_bank_if bus ();

  dip_switch_bank #(
    .NUM_BANKS (2),
    .WORD_W    (16),
    .BASE_ADDR (BASE),
    .DEFAULTS  (DEFS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bridge     (bus),
    .apply_ok   (apply_ok),
    .dip_active (dip_active),
    .dirty      (dirty),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-22s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [31:0] ofs, input logic [31:0] data);
    bus.bridge_addr    = BASE + ofs;
    bus.bridge_wr_data = data;
    bus.bridge_wr      = 1'b1;
    tick();
    bus.bridge_wr      = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] ofs, input logic [31:0] exp);
    bus.bridge_addr = BASE + ofs;
    bus.bridge_rd   = 1'b1;
    tick();
    bus.bridge_rd   = 1'b0;
    chk(tag, bus.bridge_rd_data, exp);
  endtask

  initial begin
    reset              = 1'b1;
    apply_ok           = 1'b0;
    bus.bridge_addr    = '0;
    bus.bridge_wr      = 1'b0;
    bus.bridge_wr_data = '0;
    bus.bridge_rd      = 1'b0;
    tick();
    tick();
    chk("reset_rd_data", bus.bridge_rd_data, 32'h0);
    reset = 1'b0;

    // 1. reset state
    chk("reset_dip", dip_active, 32'h9CF7_00FF);
    chk("reset_flags", {30'd0, busy, dirty}, 32'h0);
    rd_chk("rd_active0", 32'h080, 32'h0000_00FF);
    rd_chk("rd_active1", 32'h084, 32'h0000_9CF7);
    rd_chk("rd_status_reset", 32'h104, 32'h0);
    rd_chk("rd_stage0_reset", 32'h000, 32'h0000_00FF);

    // 2. staged write, apply held off until apply_ok
    bus_wr(32'h000, 32'hFFFF_1234);
    bus_wr(32'h100, 32'h1);
    chk("apply_held_dip", dip_active, 32'h9CF7_00FF);
    rd_chk("status_pending", 32'h104, 32'h5);
    rd_chk("stage0_trunc", 32'h000, 32'h0000_1234);
    chk("rd_hold", bus.bridge_rd_data, 32'h0000_1234);
    tick();
    chk("rd_hold_idle", bus.bridge_rd_data, 32'h0000_1234);
    apply_ok = 1'b1;
    tick();
    apply_ok = 1'b0;
    chk("commit_dip", dip_active, 32'h9CF7_1234);
    rd_chk("status_after_commit", 32'h104, 32'h0);
    rd_chk("rd_active0_commit", 32'h080, 32'h0000_1234);

    // 3. restore lasts exactly two cycles and drops writes
    bus_wr(32'h004, 32'h0000_AAAA);
    chk("busy_before", {31'd0, busy}, 32'h0);
    bus_wr(32'h100, 32'h2);
    chk("busy_cycle1", {31'd0, busy}, 32'h1);
    tick();
    chk("busy_cycle2", {31'd0, busy}, 32'h1);
    bus_wr(32'h000, 32'h0000_5555);
    chk("busy_done", {31'd0, busy}, 32'h0);
    rd_chk("restore_stage0", 32'h000, 32'h0000_00FF);
    rd_chk("restore_stage1", 32'h004, 32'h0000_9CF7);
    rd_chk("restore_active0", 32'h080, 32'h0000_1234);
    rd_chk("restore_status", 32'h104, 32'h1);
    chk("restore_dip", dip_active, 32'h9CF7_1234);

    // 4. restore + apply together with apply_ok held
    apply_ok = 1'b1;
    bus_wr(32'h100, 32'h3);
    chk("both_busy1", {31'd0, busy}, 32'h1);
    chk("both_dip1", dip_active, 32'h9CF7_1234);
    tick();
    chk("both_busy2", {31'd0, busy}, 32'h1);
    chk("both_dip2", dip_active, 32'h9CF7_1234);
    tick();
    chk("both_idle_dip", dip_active, 32'h9CF7_1234);
    tick();
    chk("both_commit_dip", dip_active, 32'h9CF7_00FF);
    apply_ok = 1'b0;
    rd_chk("both_status", 32'h104, 32'h0);

    // 5. staging write coincident with commit
    bus_wr(32'h000, 32'h0000_1111);
    bus_wr(32'h100, 32'h1);
    rd_chk("coinc_status_pend", 32'h104, 32'h5);
    apply_ok = 1'b1;
    bus_wr(32'h000, 32'h0000_2222);
    apply_ok = 1'b0;
    chk("coinc_dip", dip_active, 32'h9CF7_1111);
    rd_chk("coinc_status", 32'h104, 32'h1);
    rd_chk("coinc_stage0", 32'h000, 32'h0000_2222);

    // 6. unmapped accesses, absent bank, reset mid-restore
    rd_chk("unmapped_108", 32'h108, 32'h0);
    rd_chk("unmapped_0c0", 32'h0C0, 32'h0);
    rd_chk("absent_active2", 32'h088, 32'h0);
    rd_chk("outside_window", 32'h200, 32'h0);
    bus_wr(32'h008, 32'h0000_7777);
    rd_chk("absent_stage0", 32'h000, 32'h0000_2222);
    rd_chk("absent_stage1", 32'h004, 32'h0000_9CF7);
    rd_chk("absent_status", 32'h104, 32'h1);
    chk("absent_dip", dip_active, 32'h9CF7_1111);
    bus_wr(32'h100, 32'h1);
    bus_wr(32'h100, 32'h2);
    chk("mid_busy", {31'd0, busy}, 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_flags", {30'd0, busy, dirty}, 32'h0);
    chk("rst_dip", dip_active, 32'h9CF7_00FF);
    chk("rst_rd_data", bus.bridge_rd_data, 32'h0);
    rd_chk("rst_status", 32'h104, 32'h0);
    rd_chk("rst_stage0", 32'h000, 32'h0000_00FF);
    tick();
    chk("rst_no_commit", dip_active, 32'h9CF7_00FF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
